rns_461_512_to_bin: RTL and testbench

Sequential residue-to-binary converter for the two-modulus residue system {461, 512}. It accepts a residue pair (x mod 461, x mod 512) and rebuilds the unique x in [0, 236031] using the Chinese Remainder Theorem. It runs the reconstruction as a multi-cycle shift-add modular multiply under a valid/ready handshake. It is the decode end of the mod-461 reduction path and returns RNS-domain results to binary.

---
 rtl/rns_461_512_to_bin_if.sv | 43 ++++
 rtl/rns_461_512_to_bin.sv | 165 ++++++++++++++++
 tb/tb_rns_461_512_to_bin.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rns_461_512_to_bin_if.sv
// ----------------------------------------------------------------------------
// rns_461_512_to_bin_if
//
// Purpose: groups the residue-pair input handshake and the reconstructed
// result handshake of rns_461_512_to_bin into one bundle.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A producer holding valid keeps its
// payload stable until that edge. Neither ready nor valid is derived
// combinationally from the other side of the same channel.
//
// Signals:
//   in_valid  (master->slave) residue pair valid
//   in_ready  (slave->master) converter can accept a pair
//   r1 [8:0]  (master->slave) x mod 461, legal 0..460
//   r2 [8:0]  (master->slave) x mod 512
//   out_valid (slave->master) reconstructed value valid
//   out_ready (master->slave) downstream accepts the result
//   out_x[17:0] (slave->master) reconstructed x, 0..236031
//   out_err   (slave->master) r1 was out of range (range-check builds only)
//
// Modports: master = upstream/downstream environment, slave = converter.
// ----------------------------------------------------------------------------
interface rns_461_512_to_bin_if;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  r1;
    logic [8:0]  r2;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_x;
    logic        out_err;

    modport master (
        output in_valid, r1, r2, out_ready,
        input  in_ready, out_valid, out_x, out_err
    );

    modport slave (
        input  in_valid, r1, r2, out_ready,
        output in_ready, out_valid, out_x, out_err
    );
endinterface

// File: rtl/rns_461_512_to_bin.sv
// ----------------------------------------------------------------------------
// rns_461_512_to_bin
//
// Purpose: sequential residue-to-binary converter for the RNS {461, 512}.
// Rebuilds x in [0, 236031] from (x mod 461, x mod 512) with the CRT form
//   x = r2 + 512 * (((r1 - r2) * 226) mod 461)
// where 226 is the inverse of 512 modulo 461. The modular multiply is done
// bit-serially (MSB first shift-add), one multiplier bit per clock.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   bus          rns_461_512_to_bin_if.slave (in/out handshakes, r1, r2,
//                out_x, out_err)
//   dbg_state_o  current FSM state (0 IDLE, 1 DIFF, 2 MUL, 3 DONE)
//
// Latency: 11 cycles from the accepting edge to out_valid; one conversion
// every 13 cycles with out_ready held high.
//
// Optional feature, macro RNS_461_RANGE_CHECK_EN: when defined, r1 >= 461 is
// flagged, the multiply is skipped and the result is out_x = 0, out_err = 1
// (out_valid 2 cycles after acceptance). When undefined, out_err is tied 0
// and an illegal r1 simply yields an unspecified out_x on normal timing.
// ----------------------------------------------------------------------------
module rns_461_512_to_bin (
    input  logic                      clk,
    input  logic                      rst_n,
    rns_461_512_to_bin_if.slave       bus,
    output logic [1:0]                dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIFF = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [9:0] M1      = 10'd461;
    localparam logic [9:0] K_INV   = 10'd226;
    localparam logic [3:0] LAST_CNT = 4'd9;

    state_t      state_q;
    logic [8:0]  r1_q;
    logic [8:0]  r2_q;
    logic [8:0]  d_q;       // multiplier, shifted left so the live bit is d_q[8]
    logic [8:0]  acc_q;
    logic [3:0]  cnt_q;     // 0..8 = multiply steps, 9 = publish result
    logic        in_ready_q;
    logic        out_valid_q;
    logic [17:0] out_x_q;
`ifdef RNS_461_RANGE_CHECK_EN
    logic        err_q;
    logic        out_err_q;
`endif

    logic [8:0]  r2m_d;
    logic [8:0]  diff_d;
    logic [8:0]  acc_dbl_d;
    logic [8:0]  acc_d;

    // Single conditional subtract: valid for any v < 2*461.
    function automatic logic [8:0] mod_fix(input logic [9:0] v);
        return (v >= M1) ? 9'(v - M1) : v[8:0];
    endfunction

    always_comb begin
        r2m_d = (r2_q >= 9'd461) ? 9'(r2_q - 9'd461) : r2_q;
        // (r1 - r2m) mod 461; the wrap branch stays in 9 bits because
        // r1 < r2m implies r1 + (461 - r2m) < 461.
        if (r1_q >= r2m_d) begin
            diff_d = r1_q - r2m_d;
        end else begin
            diff_d = r1_q + (9'd461 - r2m_d);
        end
        acc_dbl_d = mod_fix({acc_q, 1'b0});
        if (d_q[8]) begin
            acc_d = mod_fix({1'b0, acc_dbl_d} + K_INV);
        end else begin
            acc_d = acc_dbl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            r1_q        <= '0;
            r2_q        <= '0;
            d_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
`ifdef RNS_461_RANGE_CHECK_EN
            err_q       <= 1'b0;
            out_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r1_q       <= bus.r1;
                        r2_q       <= bus.r2;
                        in_ready_q <= 1'b0;
                        state_q    <= S_DIFF;
                    end
                end
                S_DIFF: begin
                    d_q     <= diff_d;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= S_MUL;
`ifdef RNS_461_RANGE_CHECK_EN
                    // Illegal r1: jump the counter to its publish value so
                    // the next cycle presents the error result.
                    if (r1_q >= 9'd461) begin
                        err_q <= 1'b1;
                        cnt_q <= LAST_CNT;
                    end else begin
                        err_q <= 1'b0;
                    end
`endif
                end
                S_MUL: begin
                    if (cnt_q == LAST_CNT) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
`ifdef RNS_461_RANGE_CHECK_EN
                        out_err_q   <= err_q;
                        out_x_q     <= err_q ? 18'd0 : {acc_q, r2_q};
`else
                        out_x_q     <= {acc_q, r2_q};
`endif
                    end else begin
                        acc_q <= acc_d;
                        d_q   <= {d_q[7:0], 1'b0};
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_x     = out_x_q;
`ifdef RNS_461_RANGE_CHECK_EN
    assign bus.out_err   = out_err_q;
`else
    assign bus.out_err   = 1'b0;
`endif
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rns_461_512_to_bin.sv
// ----------------------------------------------------------------------------
// tb_rns_461_512_to_bin
//
// Directed vectors with hand-computed residues and results, a short random
// sweep, backpressure, mid-operation reset and the out-of-range r1 case.
// Expected results go into exp_q when a pair is accepted; a monitor pops and
// compares on every output handshake (value, error flag and latency).
// Expected-queue word: {check_x, err, latency[3:0], x[17:0]}.
// ----------------------------------------------------------------------------
module tb_rns_461_512_to_bin;

    localparam int W = 24;
    localparam logic [1:0] ST_IDLE = 2'd0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rns_461_512_to_bin_if bus();
    logic [1:0] dbg_state;

    rns_461_512_to_bin dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           acc_cyc_q[$];

    // out_ready is owned by this one process: fixed level or random.
    logic rdy_fixed = 1'b1;
    logic rand_rdy  = 1'b0;
    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_rdy ? ($urandom_range(0, 1) != 0) : rdy_fixed;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [8:0] r1, input logic [8:0] r2,
                        input logic [17:0] x, input logic err,
                        input logic chk_x, input logic [3:0] lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stuck at 0 (cycle %0d)", cyc);
            return;
        end
        bus.in_valid = 1'b1;
        bus.r1 = r1;
        bus.r2 = r2;
        @(posedge clk);
        exp_q.push_back({chk_x, err, lat, x});
        acc_cyc_q.push_back(cyc);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
            exp_q.delete();
            acc_cyc_q.delete();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic prev_ov  = 1'b0;
    int   rise_cyc = 0;
    always @(negedge clk) begin
        logic [W-1:0] e;
        int a;
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov) rise_cyc = cyc;
            prev_ov = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: out_x %0d with empty queue", bus.out_x);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_cyc_q.pop_front();
                    if (e[23]) check("out_x", int'(bus.out_x), int'(e[17:0]));
                    check("out_err", int'(bus.out_err), int'(e[22]));
                    check("latency", rise_cyc - a - 1, int'(e[21:18]));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int x;
        int n;
        bus.in_valid = 1'b0;
        bus.r1 = '0;
        bus.r2 = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_x",     int'(bus.out_x), 0);
        check("rst_out_err",   int'(bus.out_err), 0);
        check("rst_state",     int'(dbg_state), int'(ST_IDLE));
        rst_n = 1'b1;

        // directed vectors, out_ready held high
        send(9'd78,  9'd488, 18'd1000,   1'b0, 1'b1, 4'd11);
        send(9'd0,   9'd0,   18'd0,      1'b0, 1'b1, 4'd11);
        send(9'd460, 9'd511, 18'd236031, 1'b0, 1'b1, 4'd11);
        send(9'd51,  9'd0,   18'd512,    1'b0, 1'b1, 4'd11);
        send(9'd0,   9'd461, 18'd461,    1'b0, 1'b1, 4'd11);
        send(9'd369, 9'd64,  18'd123456, 1'b0, 1'b1, 4'd11);
        send(9'd387, 9'd320, 18'd200000, 1'b0, 1'b1, 4'd11);
        send(9'd316, 9'd265, 18'd777,    1'b0, 1'b1, 4'd11);
        send(9'd459, 9'd510, 18'd236030, 1'b0, 1'b1, 4'd11);
        drain();

        // random x with random out_ready
        rand_rdy = 1'b1;
        send(9'd78, 9'd488, 18'd1000, 1'b0, 1'b1, 4'd11);
        for (int i = 0; i < 24; i++) begin
            x = $urandom_range(0, 236031);
            send(9'(x % 461), 9'(x % 512), 18'(x), 1'b0, 1'b1, 4'd11);
        end
        drain();
        rand_rdy = 1'b0;

        // backpressure: hold the result for 20 cycles, ignore a new in_valid
        rdy_fixed = 1'b0;
        @(posedge clk);
        #2;
        send(9'd78, 9'd488, 18'd1000, 1'b0, 1'b1, 4'd11);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_rise", int'(bus.out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 3) begin
                bus.in_valid = 1'b1;
                bus.r1 = 9'd5;
                bus.r2 = 9'd7;
            end
            if (i == 8) bus.in_valid = 1'b0;
            check("bp_out_x",    int'(bus.out_x), 1000);
            check("bp_in_ready", int'(bus.in_ready), 0);
        end
        rdy_fixed = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("bp_release_state", int'(dbg_state), int'(ST_IDLE));
        check("bp_release_ready", int'(bus.in_ready), 1);
        check("bp_release_valid", int'(bus.out_valid), 0);
        drain();

        // reset during MUL (edge T+5) aborts without output
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.r1 = 9'd78;
        bus.r2 = 9'd488;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_state",     int'(dbg_state), int'(ST_IDLE));
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_x",     int'(bus.out_x), 0);
        check("midrst_in_ready",  int'(bus.in_ready), 1);
        rst_n = 1'b1;
        send(9'd78, 9'd488, 18'd1000, 1'b0, 1'b1, 4'd11);
        drain();

        // out-of-range r1
`ifdef RNS_461_RANGE_CHECK_EN
        send(9'd461, 9'd5, 18'd0, 1'b1, 1'b1, 4'd2);
`else
        send(9'd461, 9'd5, 18'd0, 1'b0, 1'b0, 4'd11);
`endif
        send(9'd78, 9'd488, 18'd1000, 1'b0, 1'b1, 4'd11);
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
